// File: rtl/sdr_rd_udp_feeder.sv
// SDRAM frame reader: issues bounded read bursts and forwards the
// returned words into the UDP FIFO, with frame markers and error flags.
module sdr_rd_udp_feeder #(
  parameter int ADDR_W      = 21,
  parameter int DATA_W      = 32,
  parameter int BURST_LEN   = 256,
  parameter int FRAME_WORDS = 786432,
  parameter int FIFO_HIGH   = 3584
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Sdr_init_done,
  input  logic              wr_done,
  input  logic              Sdr_busy,
  output logic              App_rd_en,
  output logic [ADDR_W-1:0] App_rd_addr,
  input  logic              Sdr_rd_en,
  input  logic [DATA_W-1:0] Sdr_rd_dout,
  input  logic [11:0]       udp_wrusedw,
  input  logic              full_flag,
  output logic              udp_fifo_wr_en,
  output logic [DATA_W-1:0] udp_fifo_wr_data,
  output logic              frame_start,
  output logic              frame_done,
  output logic              rd_err,
  output logic              fifo_ovf
);

  typedef enum logic [1:0] {IDLE, CHECK, REQ, DRAIN} state_t;

  localparam int CW  = 11;
  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0]   FW   = AW1'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [CW-1:0]     BL   = CW'(BURST_LEN);
  localparam logic [11:0]       FH   = 12'(FIFO_HIGH);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] rx;
  logic [CW-1:0]     blen;
  logic [CW-1:0]     issued;
  logic [CW-1:0]     outst;
  logic              frm_end;

  logic              accept;
  logic              ret;
  logic              stray;
  logic              last_req;
  logic [ADDR_W:0]   remain;
  logic [CW-1:0]     burst;
  logic [CW-1:0]     outst_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  assign accept    = App_rd_en & ~Sdr_busy;
  assign ret       = Sdr_rd_en & (outst != '0);
  assign stray     = Sdr_rd_en & (outst == '0);
  assign last_req  = accept & ((issued + CW'(1)) == blen);
  assign remain    = FW - {1'b0, addr};
  assign burst     = (remain < AW1'(BURST_LEN)) ? CW'(remain) : BL;
  assign outst_nxt = outst + CW'(accept) - CW'(ret);
  assign addr_nxt  = (addr == LAST) ? '0 : addr + ADDR_W'(1);
  assign App_rd_addr = addr;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state            <= IDLE;
      addr             <= '0;
      rx               <= '0;
      blen             <= '0;
      issued           <= '0;
      outst            <= '0;
      frm_end          <= 1'b0;
      App_rd_en        <= 1'b0;
      udp_fifo_wr_en   <= 1'b0;
      udp_fifo_wr_data <= '0;
      frame_start      <= 1'b0;
      frame_done       <= 1'b0;
      rd_err           <= 1'b0;
      fifo_ovf         <= 1'b0;
    end else begin
      frame_start      <= accept & (addr == '0);
      udp_fifo_wr_en   <= ret;
      udp_fifo_wr_data <= Sdr_rd_dout;
      frame_done       <= ret & (rx == LAST);
      rd_err           <= rd_err | stray;
      fifo_ovf         <= fifo_ovf | (udp_fifo_wr_en & full_flag);
      outst            <= outst_nxt;
      // rx tracks the frame position of returned words
      if (ret)
        rx <= (rx == LAST) ? '0 : rx + ADDR_W'(1);
      if (accept) begin
        addr   <= addr_nxt;
        issued <= issued + CW'(1);
        if (addr == LAST)
          frm_end <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (Sdr_init_done && wr_done) begin
            state   <= CHECK;
            addr    <= '0;
            frm_end <= 1'b0;
          end
        end
        CHECK: begin
          if (udp_wrusedw <= FH && !full_flag) begin
            state     <= REQ;
            App_rd_en <= 1'b1;
            blen      <= burst;
            issued    <= '0;
          end
        end
        REQ: begin
          if (last_req) begin
            state     <= DRAIN;
            App_rd_en <= 1'b0;
          end
        end
        DRAIN: begin
          if (outst == '0) begin
            if (frm_end) begin
              frm_end <= 1'b0;
              if (wr_done) begin
                state <= CHECK;
                addr  <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              state <= CHECK;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdr_rd_udp_feeder.sv
// Bench for sdr_rd_udp_feeder: scoreboard of requests and returns
// against a fixed-latency SDRAM responder, plus directed scenarios.
module tb_sdr_rd_udp_feeder;

  localparam int AW = 21;
  localparam int DW = 32;
  localparam int BL = 4;
  localparam int FW = 10;
  localparam int FH = 3584;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Sdr_init_done;
  logic          wr_done;
  logic          Sdr_busy;
  logic          App_rd_en;
  logic [AW-1:0] App_rd_addr;
  logic          Sdr_rd_en;
  logic [DW-1:0] Sdr_rd_dout;
  logic [11:0]   udp_wrusedw;
  logic          full_flag;
  logic          udp_fifo_wr_en;
  logic [DW-1:0] udp_fifo_wr_data;
  logic          frame_start;
  logic          frame_done;
  logic          rd_err;
  logic          fifo_ovf;

  always #5 Clk = ~Clk;

  sdr_rd_udp_feeder #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL),
    .FRAME_WORDS(FW), .FIFO_HIGH(FH)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Sdr_init_done(Sdr_init_done),
    .wr_done(wr_done), .Sdr_busy(Sdr_busy),
    .App_rd_en(App_rd_en), .App_rd_addr(App_rd_addr),
    .Sdr_rd_en(Sdr_rd_en), .Sdr_rd_dout(Sdr_rd_dout),
    .udp_wrusedw(udp_wrusedw), .full_flag(full_flag),
    .udp_fifo_wr_en(udp_fifo_wr_en),
    .udp_fifo_wr_data(udp_fifo_wr_data),
    .frame_start(frame_start), .frame_done(frame_done),
    .rd_err(rd_err), .fifo_ovf(fifo_ovf)
  );

  int checks = 0;
  int errors = 0;

  int out_m, exp_addr, burst_cnt, burst_start;
  int n_acc, n_fwd, n_fdone, n_fstart;
  bit m_err, m_ovf, prev_en, burst_end, stray;
  int q[$];
  int blens[$];
  int accs[$];
  bit pv[3];
  logic [31:0] pd[3];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dat(int a);
    return 32'hDA7A0000 | 32'(a);
  endfunction

  // One clock: account for what the next edge samples, then compare
  task automatic tick();
    bit s_rst, s_acc, s_ret, s_ovf;
    bit e_wr, e_fs, e_fd, nv;
    int s_addr, mn;
    logic [31:0] e_data, nd;
    s_rst  = Rst;
    s_acc  = App_rd_en && !Sdr_busy;
    s_addr = int'(App_rd_addr);
    s_ret  = Sdr_rd_en;
    s_ovf  = udp_fifo_wr_en && full_flag;
    e_wr = 0; e_fs = 0; e_fd = 0; e_data = '0;
    burst_end = 0;
    if (s_rst) begin
      out_m = 0; exp_addr = 0; q.delete();
      m_err = 0; m_ovf = 0; burst_cnt = 0;
    end else begin
      if (s_ret) begin
        if (out_m > 0) begin
          e_wr = 1;
          e_data = dat(q[0]);
          e_fd = (q[0] == FW - 1);
          void'(q.pop_front());
          out_m--;
          n_fwd++;
        end else begin
          m_err = 1;
        end
      end
      if (s_ovf) m_ovf = 1;
      if (s_acc) begin
        chk("req_addr", 32'(s_addr), 32'(exp_addr));
        e_fs = (exp_addr == 0);
        q.push_back(exp_addr);
        accs.push_back(s_addr);
        if (burst_cnt == 0) burst_start = exp_addr;
        burst_cnt++;
        exp_addr = (exp_addr + 1) % FW;
        out_m++;
        n_acc++;
      end
    end
    nv = pv[2];
    nd = pv[2] ? pd[2] : '0;
    pv[2] = pv[1]; pd[2] = pd[1];
    pv[1] = pv[0]; pd[1] = pd[0];
    pv[0] = s_acc && !s_rst; pd[0] = dat(s_addr);
    if (stray) begin
      nv = 1; nd = 32'hBAD0BAD0; stray = 0;
    end
    @(negedge Clk);
    Sdr_rd_en = nv;
    Sdr_rd_dout = nd;
    chk("wr_en", 32'(udp_fifo_wr_en), 32'(e_wr));
    if (e_wr) chk("wr_data", udp_fifo_wr_data, e_data);
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("rd_err", 32'(rd_err), 32'(m_err));
    chk("fifo_ovf", 32'(fifo_ovf), 32'(m_ovf));
    if (s_rst) begin
      chk("rst_rd_en", 32'(App_rd_en), 32'd0);
      chk("rst_addr", 32'(App_rd_addr), 32'd0);
      prev_en = 0;
    end
    if (e_fd) n_fdone++;
    if (e_fs) n_fstart++;
    if (prev_en && !App_rd_en) begin
      mn = (BL < FW - burst_start) ? BL : FW - burst_start;
      blens.push_back(burst_cnt);
      chk("burst_len", 32'(burst_cnt), 32'(mn));
      burst_cnt = 0;
      burst_end = 1;
    end
    prev_en = App_rd_en;
  endtask

  task automatic wait_fd(int target, int lim);
    int n = 0;
    while (n_fdone < target && n < lim) begin tick(); n++; end
    chk("wait_frame_done", 32'(n_fdone >= target), 32'd1);
  endtask

  task automatic wait_bc(int target, int lim);
    int n = 0;
    while (burst_cnt != target && n < lim) begin tick(); n++; end
    chk("wait_burst_cnt", 32'(burst_cnt), 32'(target));
  endtask

  task automatic wait_be(int lim);
    int n = 0;
    tick();
    while (!burst_end && n < lim) begin tick(); n++; end
    chk("wait_burst_end", 32'(burst_end), 32'd1);
  endtask

  task automatic wait_fs(int target, int lim);
    int n = 0;
    while (n_fstart < target && n < lim) begin tick(); n++; end
    chk("wait_frame_start", 32'(n_fstart >= target), 32'd1);
  endtask

  initial begin
    int a, f;
    Rst = 1; Sdr_init_done = 0; wr_done = 0; Sdr_busy = 0;
    Sdr_rd_en = 0; Sdr_rd_dout = '0; udp_wrusedw = '0; full_flag = 0;
    out_m = 0; exp_addr = 0; burst_cnt = 0; burst_start = 0;
    n_acc = 0; n_fwd = 0; n_fdone = 0; n_fstart = 0;
    m_err = 0; m_ovf = 0; prev_en = 0; burst_end = 0; stray = 0;
    for (int i = 0; i < 3; i++) begin pv[i] = 0; pd[i] = '0; end

    repeat (4) tick();
    chk("reset_wr_en", 32'(udp_fifo_wr_en), 32'd0);
    chk("reset_rd_err", 32'(rd_err), 32'd0);
    Rst = 0;
    tick();

    // two complete frames back to back
    Sdr_init_done = 1; wr_done = 1;
    wait_fd(2, 400);
    chk("burst0", 32'(blens[0]), 32'd4);
    chk("burst1", 32'(blens[1]), 32'd4);
    chk("burst2", 32'(blens[2]), 32'd2);
    chk("burst3", 32'(blens[3]), 32'd4);
    chk("addr9", 32'(accs[9]), 32'd9);
    chk("addr_wrap", 32'(accs[10]), 32'd0);
    chk("fwd_two_frames", 32'(n_fwd), 32'd20);
    chk("frame_starts", 32'(n_fstart), 32'd2);

    // wr_done low at frame end -> idle, no further requests
    wr_done = 0;
    repeat (40) tick();
    chk("idle_no_req", 32'(n_acc), 32'd20);
    chk("idle_rd_en", 32'(App_rd_en), 32'd0);

    // controller busy for 5 cycles after 2 requests
    wr_done = 1;
    wait_bc(2, 40);
    Sdr_busy = 1;
    repeat (5) begin
      tick();
      chk("busy_hold_addr", 32'(App_rd_addr), 32'd2);
    end
    Sdr_busy = 0;
    wait_be(40);
    chk("busy_burst_len", 32'(blens[blens.size()-1]), 32'd4);

    // FIFO threshold
    udp_wrusedw = 12'(FH + 1);
    a = n_acc;
    repeat (20) tick();
    chk("fifo_high_block", 32'(n_acc), 32'(a));
    chk("fifo_high_rd_en", 32'(App_rd_en), 32'd0);
    udp_wrusedw = 12'(FH);
    tick();
    chk("fifo_high_start", 32'(App_rd_en), 32'd1);

    // full FIFO during drain
    wait_be(40);
    full_flag = 1;
    a = n_acc; f = n_fwd;
    repeat (20) tick();
    chk("full_words_written", 32'(n_fwd > f), 32'd1);
    chk("full_ovf", 32'(fifo_ovf), 32'd1);
    chk("full_block", 32'(n_acc), 32'(a));
    full_flag = 0;
    tick();
    chk("full_release", 32'(App_rd_en), 32'd1);

    // stray return while idle
    Rst = 1;
    repeat (5) tick();
    Rst = 0; Sdr_init_done = 0;
    tick();
    f = n_fwd;
    stray = 1;
    repeat (5) tick();
    chk("stray_rd_err", 32'(rd_err), 32'd1);
    chk("stray_not_fwd", 32'(n_fwd), 32'(f));

    // reset after 2 of 4 requests, then restart
    Rst = 1;
    repeat (5) tick();
    chk("rst_clears_err", 32'(rd_err), 32'd0);
    chk("rst_clears_ovf", 32'(fifo_ovf), 32'd0);
    Rst = 0; Sdr_init_done = 1;
    wait_bc(2, 40);
    Rst = 1;
    tick();
    chk("midrst_rd_en", 32'(App_rd_en), 32'd0);
    chk("midrst_addr", 32'(App_rd_addr), 32'd0);
    chk("midrst_wr_en", 32'(udp_fifo_wr_en), 32'd0);
    repeat (4) tick();
    Rst = 0;
    a = n_fstart;
    wait_fs(a + 1, 40);
    chk("restart_addr", 32'(accs[accs.size()-1]), 32'd0);
    wait_fd(n_fdone + 1, 200);
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdr_rd_udp_feeder.md
SDR_RD_UDP_FEEDER -- requirements
Module: sdr_rd_udp_feeder

Interface
REQ-001 Parameter ADDR_W, default 21, SDRAM word-address width (2M x 32 device).
REQ-002 Parameter DATA_W, default 32, SDRAM data width.
REQ-003 Parameter BURST_LEN, default 256, maximum read requests per burst, range 1..1024.
REQ-004 Parameter FRAME_WORDS, default 786432, words per frame; any value 1..2^ADDR_W is legal.
REQ-005 Parameter FIFO_HIGH, default 3584, largest udp_wrusedw at which a burst may start.
REQ-006 Clk  in  1  single clock, the SDRAM controller clock; all logic rising-edge.
REQ-007 Rst  in  1  reset, synchronous, active-high.
REQ-008 Sdr_init_done  in  1  SDRAM initialisation complete.
REQ-009 wr_done  in  1  level-high once a full frame has been written to SDRAM.
REQ-010 Sdr_busy  in  1  controller cannot accept a request this cycle.
REQ-011 App_rd_en  out  1  read request, one word per accepted cycle.
REQ-012 App_rd_addr  out  ADDR_W  word address of the current request.
REQ-013 Sdr_rd_en  in  1  read data valid from the controller.
REQ-014 Sdr_rd_dout  in  DATA_W  read data.
REQ-015 udp_wrusedw  in  12  fill level of the downstream UDP FIFO.
REQ-016 full_flag  in  1  downstream UDP FIFO full.
REQ-017 udp_fifo_wr_en  out  1  write strobe to the UDP FIFO.
REQ-018 udp_fifo_wr_data  out  DATA_W  data to the UDP FIFO.
REQ-019 frame_start  out  1  one-cycle pulse when the first request of a frame is accepted.
REQ-020 frame_done  out  1  one-cycle pulse when the last word of a frame is forwarded.
REQ-021 rd_err  out  1  sticky flag: read data arrived with no requests outstanding.
REQ-022 fifo_ovf  out  1  sticky flag: a word was forwarded while full_flag=1.

Function
REQ-023 The FSM SHALL have states IDLE, CHECK, REQ, DRAIN.
REQ-024 IDLE->CHECK SHALL occur when Sdr_init_done=1 and wr_done=1; the address is then set to 0.
REQ-025 CHECK->REQ SHALL occur when udp_wrusedw<=FIFO_HIGH and full_flag=0; the burst length is then latched as min(BURST_LEN, FRAME_WORDS-addr).
REQ-026 In REQ, App_rd_en SHALL be 1; a request is accepted in any cycle with App_rd_en=1 and Sdr_busy=0.
REQ-027 On each acceptance the address SHALL increment by 1, and the issued and outstanding counts SHALL each increment by 1.
REQ-028 App_rd_addr SHALL be held stable while Sdr_busy=1.
REQ-029 REQ->DRAIN SHALL occur on acceptance of the last request of the burst; App_rd_en SHALL be 0 in the following cycle.
REQ-030 In DRAIN, the FSM SHALL go to CHECK when outstanding=0 and the frame is not complete.
REQ-031 In DRAIN, when outstanding=0 and the frame is complete, the FSM SHALL go to CHECK with addr=0 if wr_done=1, otherwise to IDLE.
REQ-032 A word received with Sdr_rd_en=1 at cycle n SHALL produce udp_fifo_wr_en=1 at cycle n+1, with udp_fifo_wr_data equal to the registered Sdr_rd_dout.
REQ-033 Each forwarded word SHALL decrement the outstanding count.
REQ-034 An acceptance and a return in the same cycle SHALL leave the outstanding count unchanged.
REQ-035 A word forwarded while full_flag=1 SHALL still be written, and SHALL set fifo_ovf.
REQ-036 A word arriving with Sdr_rd_en=1 while outstanding=0 SHALL be discarded, not forwarded, and SHALL set rd_err.
REQ-037 frame_start SHALL pulse on acceptance of address 0.
REQ-038 frame_done SHALL pulse with udp_fifo_wr_en for the word of address FRAME_WORDS-1.
REQ-039 At the frame end the address SHALL wrap to 0, never to FRAME_WORDS.
REQ-040 wr_done falling mid-frame SHALL NOT abort the frame; it is sampled only at the frame end.
REQ-041 The outstanding counter SHALL be 11 bits and SHALL never exceed BURST_LEN.

Reset
REQ-042 Rst=1 SHALL force, on the next edge: state IDLE, address 0, all counters 0, and all outputs 0, including rd_err and fifo_ovf.
REQ-043 Reset mid-burst SHALL abandon the burst; any later stray returns are handled per REQ-036.

Verification
REQ-044 BURST_LEN=4, FRAME_WORDS=10, fixed read latency 3, wr_done=1 -> bursts of 4, 4, 2; addresses 0..9 then back to 0; frame_done once per 10 words; data forwarded in order.
REQ-045 Sdr_busy=1 for 5 cycles mid-burst -> App_rd_addr held; no duplicate or skipped address; total requests per burst = 4.
REQ-046 udp_wrusedw=FIFO_HIGH+1 -> stays in CHECK with App_rd_en=0; udp_wrusedw=FIFO_HIGH -> burst starts on the next edge.
REQ-047 Sdr_rd_en pulse while IDLE -> no udp_fifo_wr_en; rd_err=1 until Rst.
REQ-048 full_flag=1 during DRAIN -> words still written; fifo_ovf=1; no next burst until full_flag=0.
REQ-049 Rst asserted after 2 of 4 requests -> all outputs 0 next cycle; restart at address 0 with frame_start.
